// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC angle sequencer: state encoding,
// core seed constant, quadrant fold and saturating negate.
package cordic_pkg;

  localparam int WIDTH = 16;
  localparam logic signed [WIDTH-1:0] X_INIT = 16'sd19898;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } cordic_state_e;

  typedef struct packed {
    logic             neg;
    logic [WIDTH-1:0] z;
  } fold_t;

  // Quadrants II and III are shifted by 180 deg into the core's +-90 deg range;
  // the result must then be negated.
  function automatic fold_t fold_phase(input logic [WIDTH-1:0] p);
    fold_t f;
    f.neg = p[WIDTH-1] ^ p[WIDTH-2];
    f.z   = f.neg ? {~p[WIDTH-1], p[WIDTH-2:0]} : p;
    return f;
  endfunction

  // Two's-complement negate; the most negative value clips to the maximum.
  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == {1'b1, {(WIDTH-1){1'b0}}}) r = {1'b0, {(WIDTH-1){1'b1}}};
    else                                r = -v;
    return r;
  endfunction

endpackage

// File: rtl/cordic_req_fifo.sv
// Small synchronous request FIFO with occupancy output; pointers wrap
// naturally because the depth is a power of two.
module cordic_req_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Buffers full-circle phase requests, folds each into the core's range,
// runs one rotation at a time and returns quadrant-corrected cos/sin.
module cordic_angle_sequencer
  import cordic_pkg::*;
#(
  parameter int                      WIDTH      = cordic_pkg::WIDTH,
  parameter int                      FIFO_DEPTH = 4,
  parameter logic signed [WIDTH-1:0] X_INIT     = cordic_pkg::X_INIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_phase,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [WIDTH-1:0]              core_x,
  output logic [WIDTH-1:0]              core_y,
  output logic [WIDTH-1:0]              core_z,
  output logic                          core_mode,
  output logic                          core_valid_in,
  input  logic                          core_valid_out,
  input  logic [WIDTH-1:0]              core_cos,
  input  logic [WIDTH-1:0]              core_sin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_cos,
  output logic [WIDTH-1:0]              out_sin,
  output logic                          busy
);

  // Handshake: a transfer occurs on a rising edge where valid && ready;
  // a producer holds valid and data stable until that edge.

  cordic_state_e    state;
  logic             neg;
  logic [WIDTH-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  fold_t            fold;

  assign in_ready  = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fold      = fold_phase(head);
  assign core_mode = 1'b1;
  assign busy      = (state != IDLE);

  cordic_req_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .din   (in_phase),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      neg           <= 1'b0;
      core_x        <= '0;
      core_y        <= '0;
      core_z        <= '0;
      core_valid_in <= 1'b0;
      out_valid     <= 1'b0;
      out_cos       <= '0;
      out_sin       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            core_z <= fold.z;
            core_x <= X_INIT;
            core_y <= '0;
            neg    <= fold.neg;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          core_valid_in <= 1'b1;
          state         <= WAIT;
        end
        WAIT: begin
          core_valid_in <= 1'b0;
          if (core_valid_out) begin
            out_cos   <= neg ? sat_neg(core_cos) : core_cos;
            out_sin   <= neg ? sat_neg(core_sin) : core_sin;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed bench for cordic_angle_sequencer with a behavioural core model
// answering from a response queue after a programmable latency.
module tb_cordic_angle_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_phase;
  logic [2:0]  fifo_level;
  logic [15:0] core_x;
  logic [15:0] core_y;
  logic [15:0] core_z;
  logic        core_mode;
  logic        core_valid_in;
  logic        core_valid_out;
  logic [15:0] core_cos;
  logic [15:0] core_sin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cos;
  logic [15:0] out_sin;
  logic        busy;

  int chk_cnt = 0;
  int err_cnt = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cordic_angle_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_phase       (in_phase),
    .fifo_level     (fifo_level),
    .core_x         (core_x),
    .core_y         (core_y),
    .core_z         (core_z),
    .core_mode      (core_mode),
    .core_valid_in  (core_valid_in),
    .core_valid_out (core_valid_out),
    .core_cos       (core_cos),
    .core_sin       (core_sin),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_cos        (out_cos),
    .out_sin        (out_sin),
    .busy           (busy)
  );

  // core model
  int          core_lat = 1;
  int          cnt;
  logic        model_vout;
  logic        stray_vout;
  logic [15:0] rc_q[$];
  logic [15:0] rs_q[$];

  assign core_valid_out = model_vout | stray_vout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 0;
      model_vout <= 1'b0;
      core_cos   <= '0;
      core_sin   <= '0;
    end else begin
      model_vout <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          model_vout <= 1'b1;
          core_cos   <= (rc_q.size() != 0) ? rc_q.pop_front() : 16'h0;
          core_sin   <= (rs_q.size() != 0) ? rs_q.pop_front() : 16'h0;
        end
      end
      if (core_valid_in) cnt <= core_lat;
    end
  end

  int max_level = 0;
  always @(negedge clk) if (!rst && int'(fifo_level) > max_level) max_level = int'(fifo_level);

  // scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic push(input logic [15:0] ph);
    int n;
    in_valid = 1'b1;
    in_phase = ph;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [15:0] ph, input logic [15:0] zexp,
                         input logic [15:0] rcos, input logic [15:0] rsin,
                         input logic [15:0] ecos, input logic [15:0] esin,
                         input bit chk_lat);
    int n;
    rc_q.push_back(rcos);
    rs_q.push_back(rsin);
    push(ph);
    n = 0;
    while (!core_valid_in && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_seen", core_valid_in, 1);
    if (chk_lat) check("issue_latency", n, 2);
    check("core_z", core_z, zexp);
    check("core_x", core_x, 16'd19898);
    check("core_y", core_y, 16'd0);
    check("core_mode", core_mode, 1);
    @(negedge clk);
    check("issue_pulse", core_valid_in, 0);
    check("core_z_stable", core_z, zexp);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid", out_valid, 1);
    check("out_cos", out_cos, ecos);
    check("out_sin", out_sin, esin);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  logic [15:0] bph  [6] = '{16'h1000, 16'h5000, 16'h9000, 16'hD000, 16'h2000, 16'hA000};
  logic [15:0] bcos [6] = '{16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd5000, 16'd6000};
  logic [15:0] bsin [6] = '{-16'sd100, -16'sd200, -16'sd300, -16'sd400, -16'sd500, -16'sd600};
  logic [15:0] ecos [6] = '{16'd1000, -16'sd2000, -16'sd3000, 16'd4000, 16'd5000, -16'sd6000};
  logic [15:0] esin [6] = '{-16'sd100, 16'd200, 16'd300, -16'sd400, -16'sd500, 16'd600};

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_phase   = '0;
    out_ready  = 1'b0;
    stray_vout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_core_z", core_z, 0);
    check("rst_core_x", core_x, 0);
    check("rst_core_mode", core_mode, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // single transactions
    run_one(16'h0000, 16'h0000, 16'd16384, 16'd0, 16'd16384, 16'd0, 1'b1);
    run_one(16'h8000, 16'h0000, 16'd16384, 16'd0, -16'sd16384, 16'd0, 1'b1);
    run_one(16'h4000, 16'hC000, 16'd0, -16'sd16384, 16'd0, 16'd16384, 1'b1);
    run_one(16'h3FFF, 16'h3FFF, 16'd1234, 16'd5678, 16'd1234, 16'd5678, 1'b1);
    run_one(16'hC000, 16'hC000, 16'd100, 16'h8000, 16'd100, 16'h8000, 1'b1);
    run_one(16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b1);

    // back-to-back burst against a slow core
    core_lat  = 10;
    max_level = 0;
    for (int i = 0; i < 6; i++) begin
      rc_q.push_back(bcos[i]);
      rs_q.push_back(bsin[i]);
      exp_q.push_back({ecos[i], esin[i]});
    end
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(bph[i]);
          if (i == 4) begin
            check("burst_level_full", fifo_level, 4);
            check("burst_in_ready_low", in_ready, 0);
          end
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          logic [31:0] e;
          int n;
          n = 0;
          while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
          end
          check("burst_out_valid", out_valid, 1);
          e = exp_q.pop_front();
          check("burst_result", {out_cos, out_sin}, e);
          if (k == 2) begin
            repeat (5) begin
              @(negedge clk);
              check("hold_valid", out_valid, 1);
              check("hold_stable", {out_cos, out_sin}, e);
            end
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end
      end
    join
    check("burst_max_level", max_level, 4);
    check("burst_drained", fifo_level, 0);

    // reset while waiting on the core with requests queued
    core_lat = 50;
    for (int i = 0; i < 4; i++) push(bph[i]);
    check("pre_rst_level", fifo_level, 3);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_core_z", core_z, 0);
    check("mid_rst_core_x", core_x, 0);
    check("mid_rst_valid_in", core_valid_in, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    rc_q.delete();
    rs_q.delete();
    @(negedge clk);
    stray_vout = 1'b1;
    @(negedge clk);
    stray_vout = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_out_valid", out_valid, 0);
      check("stray_busy", busy, 0);
      check("stray_level", fifo_level, 0);
    end

    // recovery after reset
    core_lat = 1;
    run_one(16'h4000, 16'hC000, 16'd300, 16'd400, -16'sd300, -16'sd400, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
